// File: rtl/costas_loop_ctrl.sv
`timescale 1ns / 1ps
// costas_loop_ctrl
//   Acquisition/tracking sequencer for the polar Costas loop. It owns the loop-filter gains,
//   the loop reset and the freeze line, and it detects lock from the phase error. Gain changes
//   reach the loop only at packet boundaries of the monitored sample stream.
// Ports
//   axis_data_clk / axis_data_rst : sole clock, synchronous active-high reset
//   s_ctrlport_req_* / resp_*     : CtrlPort register bank, ack one cycle after a mapped request
//   mon_tvalid/tready/tlast       : observed handshake of the sample stream (packet framing)
//   phase_err / phase_err_valid   : signed loop phase error and its qualifier
//   loop_kp / loop_ki             : applied proportional / integral gains
//   loop_rst / loop_freeze        : loop reset and NCO/integrator hold
//   locked / state                : TRACK indicator and FSM state (0 DIS,1 FLUSH,2 ACQ,3 TRK)
module costas_loop_ctrl #(
   parameter int unsigned ERR_W            = 16,
   parameter int unsigned GAIN_W           = 16,
   parameter int unsigned FLUSH_CYCLES     = 16,
   parameter logic [31:0] DEF_ACQ_GAINS    = 32'h0,
   parameter logic [31:0] DEF_TRK_GAINS    = 32'h0,
   parameter int unsigned DEF_LOCK_THRESH  = 1024,
   parameter int unsigned DEF_LOCK_COUNT   = 256,
   parameter int unsigned DEF_UNLOCK_COUNT = 64
) (
   input  logic                    axis_data_clk,
   input  logic                    axis_data_rst,
   input  logic                    s_ctrlport_req_wr,
   input  logic                    s_ctrlport_req_rd,
   input  logic [19:0]             s_ctrlport_req_addr,
   input  logic [31:0]             s_ctrlport_req_data,
   output logic                    s_ctrlport_resp_ack,
   output logic [31:0]             s_ctrlport_resp_data,
   input  logic                    mon_tvalid,
   input  logic                    mon_tready,
   input  logic                    mon_tlast,
   input  logic signed [ERR_W-1:0] phase_err,
   input  logic                    phase_err_valid,
   output logic [GAIN_W-1:0]       loop_kp,
   output logic [GAIN_W-1:0]       loop_ki,
   output logic                    loop_rst,
   output logic                    loop_freeze,
   output logic                    locked,
   output logic [1:0]              state
);

   localparam logic [19:0] AddrCtrl     = 20'h00;
   localparam logic [19:0] AddrAcq      = 20'h04;
   localparam logic [19:0] AddrTrk      = 20'h08;
   localparam logic [19:0] AddrThresh   = 20'h0C;
   localparam logic [19:0] AddrLockCnt  = 20'h10;
   localparam logic [19:0] AddrUnlkCnt  = 20'h14;
   localparam logic [19:0] AddrStatus   = 20'h18;

   localparam logic [15:0]      FlushLast = 16'(FLUSH_CYCLES - 1);
   localparam logic [ERR_W-1:0] ErrMin    = {1'b1, {(ERR_W-1){1'b0}}};
   localparam logic [ERR_W-1:0] ErrMax    = {1'b0, {(ERR_W-1){1'b1}}};

   typedef enum logic [1:0] {
      StDisabled = 2'd0,
      StFlush    = 2'd1,
      StAcquire  = 2'd2,
      StTrack    = 2'd3
   } state_e;

   // Register bank
   logic             ctrl_en_q, ctrl_frz_q, soft_rst_q;
   logic [31:0]      acq_q, trk_q;
   logic [ERR_W-1:0] thresh_q;
   logic [15:0]      lock_cnt_q, unlock_cnt_q;

   // Sequencer state
   state_e      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] flush_q, flush_d;
   logic [15:0] lost_q, lost_d;
   logic        in_pkt_q, in_pkt_d;
   logic [31:0] gains_q, gains_d;

   // CtrlPort response
   logic        ack_q, ack_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] rd_val;
   logic        mapped;

   // Lock detection
   logic [ERR_W-1:0] err_mag;
   logic             err_in;
   logic [16:0]      cnt_inc, lock_eff, unlock_eff;
   logic             fire, boundary;

   always_comb begin
      if (phase_err[ERR_W-1]) begin
         // The most negative code has no positive counterpart; clamp it.
         err_mag = (phase_err == ErrMin) ? ErrMax : ERR_W'(-phase_err);
      end else begin
         err_mag = phase_err;
      end
   end

   assign err_in     = phase_err_valid && (err_mag < thresh_q);
   assign cnt_inc    = {1'b0, cnt_q} + 17'd1;
   assign lock_eff   = {1'b0, (lock_cnt_q == 16'd0) ? 16'd1 : lock_cnt_q};
   assign unlock_eff = {1'b0, (unlock_cnt_q == 16'd0) ? 16'd1 : unlock_cnt_q};

   assign fire     = mon_tvalid && mon_tready;
   assign boundary = (fire && mon_tlast) || (!in_pkt_q && !fire);
   assign in_pkt_d = fire ? !mon_tlast : in_pkt_q;

   // Next-state logic for the sequencer
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      flush_d = flush_q;
      lost_d  = lost_q;
      if (!ctrl_en_q) begin
         state_d = StDisabled;
         cnt_d   = '0;
         flush_d = '0;
      end else if (soft_rst_q && (state_q != StDisabled)) begin
         state_d = StFlush;
         cnt_d   = '0;
         flush_d = '0;
      end else begin
         unique case (state_q)
            StDisabled: begin
               state_d = StFlush;
               cnt_d   = '0;
               flush_d = '0;
            end
            StFlush: begin
               // Flush keeps counting even while frozen.
               if (flush_q == FlushLast) begin
                  state_d = StAcquire;
                  cnt_d   = '0;
               end else begin
                  flush_d = flush_q + 16'd1;
               end
            end
            StAcquire: begin
               if (!ctrl_frz_q && phase_err_valid) begin
                  if (!err_in) begin
                     cnt_d = '0;
                  end else if (cnt_inc >= lock_eff) begin
                     state_d = StTrack;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_inc[15:0];
                  end
               end
            end
            StTrack: begin
               if (!ctrl_frz_q && phase_err_valid) begin
                  if (err_in) begin
                     cnt_d = '0;
                  end else if (cnt_inc >= unlock_eff) begin
                     state_d = StAcquire;
                     cnt_d   = '0;
                     if (lost_q != 16'hFFFF) lost_d = lost_q + 16'd1;
                  end else begin
                     cnt_d = cnt_inc[15:0];
                  end
               end
            end
         endcase
      end
   end

   // Gain update: immediate while the loop is held in reset, otherwise only between packets.
   always_comb begin
      gains_d = gains_q;
      if ((state_d == StDisabled) || (state_d == StFlush)) begin
         gains_d = acq_q;
      end else if (boundary) begin
         gains_d = (state_q == StTrack) ? trk_q : acq_q;
      end
   end

   // Read decode
   always_comb begin
      rd_val = '0;
      mapped = 1'b1;
      case (s_ctrlport_req_addr)
         AddrCtrl:    rd_val = {29'd0, ctrl_frz_q, 1'b0, ctrl_en_q};
         AddrAcq:     rd_val = acq_q;
         AddrTrk:     rd_val = trk_q;
         AddrThresh:  rd_val[ERR_W-1:0] = thresh_q;
         AddrLockCnt: rd_val[15:0] = lock_cnt_q;
         AddrUnlkCnt: rd_val[15:0] = unlock_cnt_q;
         AddrStatus:  rd_val = {lost_q, 13'd0, (state_q == StTrack), state_q};
         default:     mapped = 1'b0;
      endcase
   end

   assign ack_d   = (s_ctrlport_req_wr || s_ctrlport_req_rd) && mapped;
   assign rdata_d = (s_ctrlport_req_rd && mapped) ? rd_val : rdata_q;

   always_ff @(posedge axis_data_clk) begin
      if (axis_data_rst) begin
         ctrl_en_q    <= 1'b0;
         ctrl_frz_q   <= 1'b0;
         soft_rst_q   <= 1'b0;
         acq_q        <= DEF_ACQ_GAINS;
         trk_q        <= DEF_TRK_GAINS;
         thresh_q     <= ERR_W'(DEF_LOCK_THRESH);
         lock_cnt_q   <= 16'(DEF_LOCK_COUNT);
         unlock_cnt_q <= 16'(DEF_UNLOCK_COUNT);
         state_q      <= StDisabled;
         cnt_q        <= '0;
         flush_q      <= '0;
         lost_q       <= '0;
         in_pkt_q     <= 1'b0;
         gains_q      <= DEF_ACQ_GAINS;
         ack_q        <= 1'b0;
         rdata_q      <= '0;
      end else begin
         soft_rst_q <= 1'b0;
         if (s_ctrlport_req_wr) begin
            case (s_ctrlport_req_addr)
               AddrCtrl: begin
                  ctrl_en_q  <= s_ctrlport_req_data[0];
                  soft_rst_q <= s_ctrlport_req_data[1];
                  ctrl_frz_q <= s_ctrlport_req_data[2];
               end
               AddrAcq:     acq_q        <= s_ctrlport_req_data;
               AddrTrk:     trk_q        <= s_ctrlport_req_data;
               AddrThresh:  thresh_q     <= s_ctrlport_req_data[ERR_W-1:0];
               AddrLockCnt: lock_cnt_q   <= s_ctrlport_req_data[15:0];
               AddrUnlkCnt: unlock_cnt_q <= s_ctrlport_req_data[15:0];
               default: ;
            endcase
         end
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         flush_q  <= flush_d;
         lost_q   <= lost_d;
         in_pkt_q <= in_pkt_d;
         gains_q  <= gains_d;
         ack_q    <= ack_d;
         rdata_q  <= rdata_d;
      end
   end

   assign s_ctrlport_resp_ack  = ack_q;
   assign s_ctrlport_resp_data = rdata_q;
   assign loop_kp              = gains_q[GAIN_W-1:0];
   assign loop_ki              = gains_q[16 +: GAIN_W];
   assign loop_rst             = (state_q == StDisabled) || (state_q == StFlush);
   assign loop_freeze          = ctrl_frz_q;
   assign locked               = (state_q == StTrack);
   assign state                = state_q;

endmodule

// File: tb/tb_costas_loop_ctrl.sv
`timescale 1ns / 1ps
module tb_costas_loop_ctrl;

   localparam logic [31:0] ACQ = 32'h0011_0022;
   localparam logic [31:0] TRK = 32'h0033_0044;
   localparam int FLUSH = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_wr = 1'b0, req_rd = 1'b0;
   logic [19:0] req_addr = '0;
   logic [31:0] req_data = '0;
   logic        resp_ack;
   logic [31:0] resp_data;
   logic        tvalid = 1'b0, tready = 1'b0, tlast = 1'b0;
   logic [15:0] err = '0;
   logic        err_valid = 1'b0;
   logic [15:0] kp, ki;
   logic        lrst, lfrz, lck;
   logic [1:0]  st;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   costas_loop_ctrl #(
      .ERR_W(16), .GAIN_W(16), .FLUSH_CYCLES(FLUSH),
      .DEF_ACQ_GAINS(ACQ), .DEF_TRK_GAINS(TRK),
      .DEF_LOCK_THRESH(1024), .DEF_LOCK_COUNT(256), .DEF_UNLOCK_COUNT(64)
   ) dut (
      .axis_data_clk(clk), .axis_data_rst(rst),
      .s_ctrlport_req_wr(req_wr), .s_ctrlport_req_rd(req_rd),
      .s_ctrlport_req_addr(req_addr), .s_ctrlport_req_data(req_data),
      .s_ctrlport_resp_ack(resp_ack), .s_ctrlport_resp_data(resp_data),
      .mon_tvalid(tvalid), .mon_tready(tready), .mon_tlast(tlast),
      .phase_err(err), .phase_err_valid(err_valid),
      .loop_kp(kp), .loop_ki(ki), .loop_rst(lrst), .loop_freeze(lfrz),
      .locked(lck), .state(st)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int          m_state, m_cnt, m_flush, m_lost, m_thr, m_lc, m_uc;
   bit          m_inpkt, m_en, m_frz, m_soft, m_ack;
   logic [31:0] m_rdata, m_acq, m_trk, m_gains;

   function automatic int mag_of(input logic [15:0] e);
      int s = int'($signed(e));
      if (s == -32768) return 32767;
      return (s < 0) ? -s : s;
   endfunction

   function automatic bit is_mapped(input logic [19:0] a);
      return a inside {20'h00, 20'h04, 20'h08, 20'h0C, 20'h10, 20'h14, 20'h18};
   endfunction

   function automatic logic [31:0] model_read(input logic [19:0] a);
      case (a)
         20'h00:  return {29'd0, m_frz, 1'b0, m_en};
         20'h04:  return m_acq;
         20'h08:  return m_trk;
         20'h0C:  return 32'(m_thr);
         20'h10:  return 32'(m_lc);
         20'h14:  return 32'(m_uc);
         20'h18:  return {16'(m_lost), 13'd0, (m_state == 3), 2'(m_state)};
         default: return 32'd0;
      endcase
   endfunction

   always @(posedge clk) begin
      int ns, ncnt, nflush, nlost, lc, uc;
      bit fire, bnd, inn;
      if (rst) begin
         m_state = 0; m_cnt = 0; m_flush = 0; m_lost = 0;
         m_thr = 1024; m_lc = 256; m_uc = 64;
         m_inpkt = 0; m_en = 0; m_frz = 0; m_soft = 0; m_ack = 0;
         m_rdata = 0; m_acq = ACQ; m_trk = TRK; m_gains = ACQ;
      end else begin
         fire = tvalid && tready;
         bnd  = (fire && tlast) || (!m_inpkt && !fire);
         inn  = err_valid && (mag_of(err) < m_thr);
         lc   = (m_lc == 0) ? 1 : m_lc;
         uc   = (m_uc == 0) ? 1 : m_uc;
         ns = m_state; ncnt = m_cnt; nflush = m_flush; nlost = m_lost;
         if (!m_en) begin
            ns = 0; ncnt = 0; nflush = 0;
         end else if (m_soft && m_state != 0) begin
            ns = 1; ncnt = 0; nflush = 0;
         end else if (m_state == 0) begin
            ns = 1; ncnt = 0; nflush = 0;
         end else if (m_state == 1) begin
            if (m_flush == FLUSH - 1) begin ns = 2; ncnt = 0; end
            else nflush = m_flush + 1;
         end else if (!m_frz && err_valid) begin
            // Acquire counts in-threshold runs; track counts out-of-threshold runs.
            if (inn == (m_state == 2)) ncnt = m_cnt + 1;
            else ncnt = 0;
            if (m_state == 2 && ncnt >= lc) begin ns = 3; ncnt = 0; end
            if (m_state == 3 && ncnt >= uc) begin
               ns = 2; ncnt = 0; nlost = (m_lost < 65535) ? m_lost + 1 : 65535;
            end
         end
         if (ns <= 1) m_gains = m_acq;
         else if (bnd) m_gains = (m_state == 3) ? m_trk : m_acq;
         m_ack = (req_wr || req_rd) && is_mapped(req_addr);
         if (req_rd && is_mapped(req_addr)) m_rdata = model_read(req_addr);
         m_state = ns; m_cnt = ncnt; m_flush = nflush; m_lost = nlost;
         if (fire) m_inpkt = !tlast;
         m_soft = 0;
         if (req_wr) begin
            case (req_addr)
               20'h00: begin m_en = req_data[0]; m_soft = req_data[1]; m_frz = req_data[2]; end
               20'h04: m_acq = req_data;
               20'h08: m_trk = req_data;
               20'h0C: m_thr = int'(req_data[15:0]);
               20'h10: m_lc  = int'(req_data[15:0]);
               20'h14: m_uc  = int'(req_data[15:0]);
               default: ;
            endcase
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("m_state", 32'(st), 32'(m_state));
         check("m_locked", 32'(lck), 32'(m_state == 3));
         check("m_loop_rst", 32'(lrst), 32'(m_state <= 1));
         check("m_freeze", 32'(lfrz), 32'(m_frz));
         check("m_kp", 32'(kp), 32'(m_gains[15:0]));
         check("m_ki", 32'(ki), 32'(m_gains[31:16]));
         check("m_ack", 32'(resp_ack), 32'(m_ack));
         check("m_rdata", resp_data, m_rdata);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic ctrl_wr(input logic [19:0] a, input logic [31:0] d);
      req_wr = 1'b1; req_addr = a; req_data = d;
      cyc();
      req_wr = 1'b0;
   endtask

   task automatic ctrl_rd(input logic [19:0] a, output logic [31:0] d);
      req_rd = 1'b1; req_addr = a;
      cyc();
      req_rd = 1'b0;
      d = resp_data;
   endtask

   task automatic send(input logic [15:0] e);
      err_valid = 1'b1; err = e;
      cyc();
      err_valid = 1'b0;
   endtask

   task automatic wait_state(input logic [1:0] s, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (st == s) break;
         cyc();
      end
      check("wait_state", 32'(st), 32'(s));
   endtask

   typedef struct {
      bit          wr;
      bit          rd;
      logic [19:0] addr;
      logic [31:0] wdata;
      bit          exp_ack;
      bit          chk_data;
      logic [31:0] exp_data;
   } vec_t;

   vec_t vecs[22];

   initial begin
      logic [31:0] d;
      int n;
      vecs[0]  = '{0, 1, 20'h18, 32'h0,         1, 1, 32'h0};
      vecs[1]  = '{1, 0, 20'h40, 32'h1234,      0, 0, 32'h0};
      vecs[2]  = '{0, 1, 20'h40, 32'h0,         0, 0, 32'h0};
      vecs[3]  = '{0, 1, 20'h1C, 32'h0,         0, 0, 32'h0};
      vecs[4]  = '{0, 1, 20'h04, 32'h0,         1, 1, ACQ};
      vecs[5]  = '{0, 1, 20'h08, 32'h0,         1, 1, TRK};
      vecs[6]  = '{0, 1, 20'h0C, 32'h0,         1, 1, 32'd1024};
      vecs[7]  = '{0, 1, 20'h10, 32'h0,         1, 1, 32'd256};
      vecs[8]  = '{0, 1, 20'h14, 32'h0,         1, 1, 32'd64};
      vecs[9]  = '{0, 1, 20'h00, 32'h0,         1, 1, 32'h0};
      vecs[10] = '{1, 0, 20'h18, 32'hFFFF_FFFF, 1, 0, 32'h0};
      vecs[11] = '{0, 1, 20'h18, 32'h0,         1, 1, 32'h0};
      vecs[12] = '{1, 0, 20'h10, 32'd8,         1, 0, 32'h0};
      vecs[13] = '{0, 1, 20'h10, 32'h0,         1, 1, 32'd8};
      vecs[14] = '{1, 0, 20'h0C, 32'hFFFF_0064, 1, 0, 32'h0};
      vecs[15] = '{0, 1, 20'h0C, 32'h0,         1, 1, 32'h64};
      vecs[16] = '{1, 0, 20'h14, 32'd4,         1, 0, 32'h0};
      vecs[17] = '{0, 1, 20'h14, 32'h0,         1, 1, 32'd4};
      vecs[18] = '{1, 0, 20'h00, 32'h6,         1, 0, 32'h0};
      vecs[19] = '{0, 1, 20'h00, 32'h0,         1, 1, 32'h4};
      vecs[20] = '{1, 0, 20'h00, 32'h0,         1, 0, 32'h0};
      vecs[21] = '{0, 1, 20'h00, 32'h0,         1, 1, 32'h0};

      repeat (3) cyc();
      rst = 1'b0;
      chk_en = 1'b1;

      // Reset state
      check("rst_state", 32'(st), 32'd0);
      check("rst_loop_rst", 32'(lrst), 32'd1);
      check("rst_locked", 32'(lck), 32'd0);
      check("rst_kp", 32'(kp), 32'h22);
      check("rst_ki", 32'(ki), 32'h11);
      check("rst_ack", 32'(resp_ack), 32'd0);

      // Register bank vectors
      foreach (vecs[i]) begin
         req_wr = vecs[i].wr; req_rd = vecs[i].rd;
         req_addr = vecs[i].addr; req_data = vecs[i].wdata;
         cyc();
         req_wr = 1'b0; req_rd = 1'b0;
         check("reg_ack", 32'(resp_ack), 32'(vecs[i].exp_ack));
         if (vecs[i].chk_data) check("reg_data", resp_data, vecs[i].exp_data);
      end

      // Enable: flush length, then lock after 8 in-threshold samples
      ctrl_wr(20'h00, 32'h1);
      wait_state(2'd1, 10);
      n = 0;
      while (st == 2'd1 && n < 100) begin
         n++;
         cyc();
      end
      check("flush_len", 32'(n), 32'(FLUSH));
      check("acq_loop_rst", 32'(lrst), 32'd0);
      for (int i = 0; i < 7; i++) send(16'd50);
      check("lock_after_7", 32'(lck), 32'd0);
      send(16'd50);
      check("lock_after_8", 32'(lck), 32'd1);
      cyc();
      check("track_kp", 32'(kp), 32'h44);
      check("track_ki", 32'(ki), 32'h33);

      // Soft reset from TRACK
      ctrl_wr(20'h00, 32'h3);
      cyc();
      check("soft_flush", 32'(st), 32'd1);
      check("soft_kp", 32'(kp), 32'h22);
      wait_state(2'd2, 40);

      // An out sample in the middle of the run restarts the count
      for (int i = 0; i < 7; i++) send(16'd50);
      send(16'hFF38);
      for (int i = 0; i < 7; i++) send(16'd50);
      check("nolock_state", 32'(st), 32'd2);
      send(16'd50);
      check("relock_state", 32'(st), 32'd3);
      cyc();

      // Loss of lock; the most negative error counts as out
      for (int i = 0; i < 3; i++) send(16'd500);
      check("unlock_3", 32'(st), 32'd3);
      send(16'h8000);
      check("unlock_state", 32'(st), 32'd2);
      ctrl_rd(20'h18, d);
      check("status_lost1", d, 32'h0001_0002);

      // TRACK entered mid-packet: gains wait for the tlast beat
      tvalid = 1'b1; tready = 1'b1; tlast = 1'b0;
      cyc();
      tvalid = 1'b0;
      for (int i = 0; i < 8; i++) send(16'd50);
      check("pkt_track", 32'(st), 32'd3);
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("pkt_hold_kp", 32'(kp), 32'h22);
      end
      tvalid = 1'b1; tready = 1'b1; tlast = 1'b1;
      check("pkt_last_kp", 32'(kp), 32'h22);
      cyc();
      tvalid = 1'b0; tlast = 1'b0;
      check("pkt_after_kp", 32'(kp), 32'h44);
      check("pkt_after_ki", 32'(ki), 32'h33);

      // Freeze holds the unlock count and state
      send(16'd500);
      send(16'd500);
      ctrl_wr(20'h00, 32'h5);
      for (int i = 0; i < 10; i++) send(16'd500);
      check("frz_state", 32'(st), 32'd3);
      check("frz_line", 32'(lfrz), 32'd1);
      ctrl_wr(20'h00, 32'h1);
      send(16'd500);
      check("frz_cnt_held", 32'(st), 32'd3);
      send(16'd500);
      check("frz_release", 32'(st), 32'd2);
      ctrl_rd(20'h18, d);
      check("status_lost2", d, 32'h0002_0002);

      // Disable together with soft reset: disable wins
      ctrl_wr(20'h00, 32'h2);
      cyc();
      check("dis_state", 32'(st), 32'd0);
      check("dis_loop_rst", 32'(lrst), 32'd1);
      check("dis_kp", 32'(kp), 32'h22);

      // Randomized run against the model
      ctrl_wr(20'h10, 32'd3);
      ctrl_wr(20'h00, 32'h1);
      for (int c = 0; c < 4000; c++) begin
         int r;
         logic [19:0] a;
         tvalid = 1'($urandom); tready = 1'($urandom); tlast = ($urandom % 4) == 0;
         err_valid = 1'($urandom);
         r = int'($urandom % 8);
         if (r < 4) begin
            err = 16'($urandom_range(0, 160));
            if ($urandom % 2 == 1) err = -err;
         end else if (r < 7) begin
            err = 16'($urandom);
         end else begin
            err = ($urandom % 2 == 1) ? 16'h8000 : 16'h7FFF;
         end
         req_wr = 1'b0; req_rd = 1'b0;
         if ($urandom % 12 == 0) begin
            r = int'($urandom % 9);
            a = (r < 7) ? 20'(r * 4) : ((r == 7) ? 20'h1C : 20'h40);
            req_addr = a;
            if ($urandom % 2 == 1) begin
               req_rd = 1'b1;
            end else begin
               req_wr = 1'b1;
               case (a)
                  20'h00:  req_data = {29'd0, ($urandom % 8) == 0, ($urandom % 8) == 0,
                                       ($urandom % 16) != 0};
                  20'h0C:  req_data = 32'($urandom_range(20, 200));
                  20'h10, 20'h14: req_data = 32'($urandom % 6);
                  default: req_data = $urandom;
               endcase
            end
         end
         cyc();
      end
      req_wr = 1'b0; req_rd = 1'b0; err_valid = 1'b0; tvalid = 1'b0;
      cyc();
      chk_en = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
